// File: rtl/seq_detect_prog.sv
// seq_detect_prog: programmable sequence-detecting state machine.
//
// The FSM steps through DEPTH programmable per-step conditions evaluated on in_vec_i.
// It reports an in-progress sequence (busy_o), holds a "found" state while the final
// condition keeps holding (found_o), pulses match_o on entry to the found state, and keeps
// a saturating count of matches.
//
// The reset program is XOR, AND, OR, OR, ... With W=2 and DEPTH=3 this reproduces the
// classic two-input Moore detector: XOR, then AND, then OR-hold.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   en_i         sample enable; the FSM only moves on enabled cycles
//   in_vec_i     W-bit input vector
//   cfg_we_i     write one step's condition; forces the FSM back to step 0
//   cfg_addr_i   step index to write; indices >= DEPTH are ignored
//   cfg_op_i     00 XOR-reduce, 01 AND-reduce, 10 OR-reduce, 11 NOR-reduce
//   overlap_i    1: a failing step re-evaluates step 0 in the same cycle
//   cnt_clr_i    synchronous clear of match_cnt_o; wins over an increment
//   busy_o       state in 1..DEPTH-1
//   found_o      state == DEPTH
//   match_o      registered one-cycle pulse on entry to DEPTH
//   match_cnt_o  saturating match count
//   state_o      current state index, for debug
module seq_detect_prog #(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNTW  = 8,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned SW   = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en_i,
  input  logic [W-1:0]    in_vec_i,
  input  logic            cfg_we_i,
  input  logic [AW-1:0]   cfg_addr_i,
  input  logic [1:0]      cfg_op_i,
  input  logic            overlap_i,
  input  logic            cnt_clr_i,
  output logic            busy_o,
  output logic            found_o,
  output logic            match_o,
  output logic [CNTW-1:0] match_cnt_o,
  output logic [SW-1:0]   state_o
);

  typedef enum logic [1:0] {
    OpXor = 2'b00,
    OpAnd = 2'b01,
    OpOr  = 2'b10,
    OpNor = 2'b11
  } op_e;

  localparam logic [SW-1:0] LastState = SW'(DEPTH);

  // Programmed conditions
  op_e cfg_q [DEPTH];
  op_e cfg_d [DEPTH];

  logic [SW-1:0]   s_q, s_d;
  logic            match_q, match_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic             cfg_wr;
  logic [DEPTH-1:0] cond;
  logic             cur_cond;
  logic             at_end;
  logic [SW-1:0]    fail_state;

  // Out-of-range addresses make the whole write a no-op, including the FSM restart.
  assign cfg_wr = cfg_we_i && (32'(cfg_addr_i) < DEPTH);
  assign at_end = (s_q == LastState);

  // Per-step condition on the current input
  always_comb begin
    cond = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      unique case (cfg_q[k])
        OpXor:   cond[k] = ^in_vec_i;
        OpAnd:   cond[k] = &in_vec_i;
        OpOr:    cond[k] = |in_vec_i;
        OpNor:   cond[k] = ~|in_vec_i;
        default: cond[k] = 1'b0;
      endcase
    end
  end

  // The found state keeps checking the last step's condition (hold mode).
  always_comb begin
    cur_cond = cond[DEPTH-1];
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (s_q == SW'(k)) begin
        cur_cond = cond[k];
      end
    end
  end

  // With overlap, the failing sample may itself start a new sequence.
  assign fail_state = (overlap_i && cond[0]) ? SW'(1) : '0;

  // Next-state and match pulse
  always_comb begin
    s_d     = s_q;
    match_d = 1'b0;
    if (cfg_wr) begin
      s_d = '0;
    end else if (en_i) begin
      if (cur_cond) begin
        s_d = at_end ? s_q : s_q + SW'(1);
      end else begin
        s_d = fail_state;
      end
      match_d = (s_d == LastState) && !at_end;
    end
  end

  // Configuration store
  always_comb begin
    cfg_d = cfg_q;
    if (cfg_wr) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        if (32'(cfg_addr_i) == 32'(k)) begin
          cfg_d[k] = op_e'(cfg_op_i);
        end
      end
    end
  end

  // Saturating match counter; clear beats increment
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (match_q && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q     <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        cfg_q[k] <= (k == 0) ? OpXor : ((k == 1) ? OpAnd : OpOr);
      end
    end else begin
      s_q     <= s_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
    end
  end

  // Moore outputs from registered state only
  assign busy_o      = (s_q != '0) && !at_end;
  assign found_o     = at_end;
  assign match_o     = match_q;
  assign match_cnt_o = cnt_q;
  assign state_o     = s_q;

endmodule
